nand_dq_ctrl: RTL and testbench

Parametrised, registered controller for the shared bidirectional NAND DQ bus. It serialises write words onto the bus through a valid/ready handshake and captures read words into a small FIFO. Every direction change inserts a programmable bus-turnaround gap, so two drivers are never enabled in the same cycle. The block sits between the command sequencer and the package DQ pins and replaces ad-hoc per-bit tristate registers.

---
 rtl/nand_dq_ctrl_if.sv | 30 +++
 rtl/nand_dq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_nand_dq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nand_dq_ctrl_if.sv
// Handshake bundle between the command sequencer and nand_dq_ctrl.
// Write stream, read-burst request, read FIFO drain, status and contention flag.
interface nand_dq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_start;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_start_ready;
  logic              rd_strobe;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              contention;
  logic              contention_clr;

  modport slave (
    input  wr_valid, wr_data, rd_start, rd_len, rd_ready, contention_clr,
    output wr_ready, rd_start_ready, rd_strobe, rd_valid, rd_data, busy, contention
  );

  modport master (
    output wr_valid, wr_data, rd_start, rd_len, rd_ready, contention_clr,
    input  wr_ready, rd_start_ready, rd_strobe, rd_valid, rd_data, busy, contention
  );
endinterface

// File: rtl/nand_dq_ctrl.sv
// Registered NAND DQ bus controller: write streaming, read capture FIFO, bus turnaround.
// Optional drive-contention monitor enabled by defining NAND_DQ_CONTENTION_EN.
module nand_dq_ctrl #(
  parameter int DATA_W     = 8,
  parameter int TURN_CYC   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DATA_W-1:0] dq,
  nand_dq_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN, SAMPLE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_WR, DIR_RD} dir_t;

  localparam int TC_W  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TC_W-1:0] TC_LOAD = TC_W'(TURN_CYC - 1);

  state_t            state, state_nx;
  dir_t              last_dir, last_dir_nx;
  logic              pend_rd, pend_rd_nx;
  logic [TC_W-1:0]   turn_cnt, turn_cnt_nx;
  logic [LEN_W-1:0]  rem, rem_nx;

  logic              dq_oe_q;
  logic [DATA_W-1:0] dq_out_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  cnt;

  logic rd_go, full, strobe, wr_ready, wr_fire, push, pop;

  assign rd_go    = (state == IDLE) && bus.rd_start && (bus.rd_len != '0);
  assign full     = (cnt == CNT_W'(FIFO_DEPTH));
  assign strobe   = (state == SAMPLE) && !full;
  // A same-cycle read request always takes the IDLE slot away from the writer.
  assign wr_ready = rst_n && ((state == IDLE) || (state == DRIVE)) &&
                    (last_dir != DIR_RD) && !rd_go;
  assign wr_fire  = bus.wr_valid && wr_ready;
  assign push     = strobe;
  assign pop      = bus.rd_ready && (cnt != '0);

  assign bus.wr_ready       = wr_ready;
  assign bus.rd_start_ready = (state == IDLE);
  assign bus.rd_strobe      = strobe;
  assign bus.busy           = (state != IDLE);
  assign bus.rd_valid       = (cnt != '0);
  assign bus.rd_data        = (cnt != '0) ? mem[rptr] : '0;

  assign dq = dq_oe_q ? dq_out_q : 'z;

  always_comb begin
    state_nx    = state;
    last_dir_nx = last_dir;
    pend_rd_nx  = pend_rd;
    turn_cnt_nx = turn_cnt;
    rem_nx      = rem;
    case (state)
      IDLE: begin
        if (rd_go) begin
          rem_nx = bus.rd_len;
          if (last_dir == DIR_WR) begin
            state_nx    = TURN;
            pend_rd_nx  = 1'b1;
            turn_cnt_nx = TC_LOAD;
          end else begin
            state_nx = SAMPLE;
          end
        end else if (wr_fire) begin
          state_nx    = DRIVE;
          last_dir_nx = DIR_WR;
        end else if (bus.wr_valid && (last_dir == DIR_RD)) begin
          state_nx    = TURN;
          pend_rd_nx  = 1'b0;
          turn_cnt_nx = TC_LOAD;
        end
      end
      DRIVE: begin
        if (!wr_fire) state_nx = IDLE;
      end
      TURN: begin
        if (turn_cnt == '0) begin
          if (pend_rd) begin
            state_nx = SAMPLE;
          end else begin
            // Bus is now released on both sides, so the writer may start cold.
            state_nx    = IDLE;
            last_dir_nx = DIR_NONE;
          end
        end else begin
          turn_cnt_nx = turn_cnt - TC_W'(1);
        end
      end
      SAMPLE: begin
        if (strobe) begin
          rem_nx = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state_nx    = IDLE;
            last_dir_nx = DIR_RD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_dir <= DIR_NONE;
      pend_rd  <= 1'b0;
      turn_cnt <= '0;
      rem      <= '0;
      dq_oe_q  <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      last_dir <= last_dir_nx;
      pend_rd  <= pend_rd_nx;
      turn_cnt <= turn_cnt_nx;
      rem      <= rem_nx;
      dq_oe_q  <= wr_fire;
      wptr     <= wptr + PTR_W'(push);
      rptr     <= rptr + PTR_W'(pop);
      cnt      <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Data registers
  always_ff @(posedge clk) begin
    if (wr_fire) dq_out_q <= bus.wr_data;
    if (push)    mem[wptr] <= dq;
  end

`ifdef NAND_DQ_CONTENTION_EN
  logic contention_q;
  logic mismatch;

  // Case inequality so an undriven or fighting bus bit also counts as a mismatch.
  assign mismatch = dq_oe_q && (dq !== dq_out_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  contention_q <= 1'b0;
    else if (mismatch)           contention_q <= 1'b1;
    else if (bus.contention_clr) contention_q <= 1'b0;
  end

  assign bus.contention = contention_q;
`else
  logic unused_contention_clr;
  assign unused_contention_clr = bus.contention_clr;
  assign bus.contention = 1'b0;
`endif

endmodule

// File: tb/tb_nand_dq_ctrl.sv
// Scoreboard bench for nand_dq_ctrl: directed writes, reads, turnaround, stall, reset and contention.
module tb_nand_dq_ctrl;
  localparam int DW    = 8;
  localparam int LW    = 12;
  localparam int TURN  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wire [DW-1:0] dq;
  nand_dq_ctrl_if #(.DATA_W(DW), .LEN_W(LW)) bus ();
  nand_dq_ctrl #(.DATA_W(DW), .TURN_CYC(TURN), .FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .dq(dq), .bus(bus)
  );

  // External NAND model: drives only while strobed, or a forced value for the contention case
  logic          force_en = 1'b0;
  logic [DW-1:0] force_val = '0;
  logic [DW-1:0] src_mem [16];
  int            src_idx = 0;
  logic          drv_en;
  logic [DW-1:0] drv_val;
  assign drv_en  = bus.rd_strobe | force_en;
  assign drv_val = force_en ? force_val : src_mem[src_idx[3:0]];
  assign dq      = drv_en ? drv_val : 8'hzz;

  always @(posedge clk) if (bus.rd_strobe) src_idx <= src_idx + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [DW-1:0] d; } wexp_t;
  wexp_t         wr_exp[$];
  logic [DW-1:0] rd_exp[$];
  int            strobe_log[$];
  int            overlap = 0;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboards whenever the DUT presents a bus word or a FIFO word
  wexp_t         mw;
  logic [DW-1:0] mr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.dq_oe_q) begin
        if (wr_exp.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_drive: got %0h expected no drive (cycle %0d)", dq, cyc);
        end else begin
          mw = wr_exp.pop_front();
          chk("drive_cycle", cyc, mw.cyc);
          if (!force_en) chk("drive_data", dq, mw.d);
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (rd_exp.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rd: got %0h expected nothing (cycle %0d)", bus.rd_data, cyc);
        end else begin
          mr = rd_exp.pop_front();
          chk("rd_data", bus.rd_data, mr);
        end
      end
      if (bus.rd_strobe) strobe_log.push_back(cyc);
      if (dut.dq_oe_q && bus.rd_strobe) overlap++;
    end
  end

  task automatic wr_word(input logic [DW-1:0] d, output int acc);
    bit ok = 0;
    wexp_t t;
    acc = -1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.wr_ready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (ok) begin
      acc = cyc; t.cyc = cyc + 1; t.d = d;
      wr_exp.push_back(t);
    end else begin
      tests++; fails++;
      $display("FAIL wr_timeout: got no wr_ready expected accept of %0h", d);
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd_req(input int len, output int acc);
    bit ok = 0;
    acc = -1;
    bus.rd_start = 1'b1;
    bus.rd_len   = LW'(len);
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.rd_start_ready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (ok) acc = cyc;
    else begin
      tests++; fails++;
      $display("FAIL rd_timeout: got no rd_start_ready expected accept");
    end
    @(posedge clk); #1;
    bus.rd_start = 1'b0;
  endtask

  task automatic push_rd(input logic [DW-1:0] v, input int i);
    src_mem[(src_idx + i) % 16] = v;
    rd_exp.push_back(v);
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = !bus.busy && (rd_exp.size() == 0) && (wr_exp.size() == 0);
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got busy=%0d expected idle", nm, bus.busy);
    end
    @(posedge clk); #1;
  endtask

  int a1, a2, st, r, base;

  initial begin
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_start = 1'b0; bus.rd_len = '0;
    bus.rd_ready = 1'b1; bus.contention_clr = 1'b0;
    for (int i = 0; i < 16; i++) src_mem[i] = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_start_ready", bus.rd_start_ready, 1);
    chk("rst_rd_strobe", bus.rd_strobe, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_contention", bus.contention, 0);
    chk("rst_oe", dut.dq_oe_q, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back writes from cold bus: no turnaround, no gap
    st = cyc;
    wr_word(8'hA5, a1);
    wr_word(8'h3C, a2);
    chk("wr_first_no_turn", a1, st);
    chk("wr_back_to_back", a2, a1 + 1);
    wait_idle("wr_pair");

    // Write then read: TURN released cycles before first strobe
    wr_word(8'h0F, a1);
    push_rd(8'h11, 0); push_rd(8'h22, 1); push_rd(8'h33, 2);
    base = strobe_log.size();
    rd_req(3, r);
    chk("wr_to_rd_accept", r, a1 + 2);
    wait_idle("rd3");
    chk("wr_to_rd_first_strobe", strobe_log[base], r + 1 + TURN);
    chk("rd3_strobes", strobe_log.size() - base, 3);

    // Long burst against a stalled consumer: stops at FIFO depth, resumes on drain
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_rd(8'h41 + 8'(i), i);
    base = strobe_log.size();
    rd_req(6, r);
    repeat (8) @(posedge clk);
    #1;
    chk("stall_strobes", strobe_log.size() - base, DEPTH);
    chk("stall_busy", bus.busy, 1);
    chk("stall_rd_valid", bus.rd_valid, 1);
    chk("stall_first_strobe", strobe_log[base], r + 1);
    bus.rd_ready = 1'b1;
    wait_idle("rd6");
    chk("rd6_strobes", strobe_log.size() - base, 6);

    // Simultaneous read request and write: read wins, write follows after TURN
    push_rd(8'h55, 0); push_rd(8'h66, 1);
    base = strobe_log.size();
    bus.rd_start = 1'b1; bus.rd_len = LW'(2);
    bus.wr_valid = 1'b1; bus.wr_data = 8'h77;
    @(negedge clk);
    chk("prio_wr_ready", bus.wr_ready, 0);
    chk("prio_rd_accept", bus.rd_start_ready, 1);
    @(posedge clk); #1;
    bus.rd_start = 1'b0;
    wr_word(8'h77, a1);
    chk("prio_rd_strobes", strobe_log.size() - base, 2);
    chk("rd_to_wr_accept", a1, strobe_log[strobe_log.size() - 1] + 2 + TURN);
    wait_idle("prio");

    // Reset in the middle of a drive cycle
    st = cyc;
    wr_word(8'hC1, a1);
    chk("pre_rst_wr_no_turn", a1, st);
    chk("pre_rst_oe", dut.dq_oe_q, 1);
    rst_n = 1'b0;
    #1;
    chk("drive_rst_oe", dut.dq_oe_q, 0);
    chk("drive_rst_busy", bus.busy, 0);
    chk("drive_rst_wr_ready", bus.wr_ready, 0);
    wr_exp.delete();
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset in the middle of a sample burst
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_rd(8'h90 + 8'(i), i);
    rd_req(5, r);
    a2 = 0;
    for (int n = 0; n < 20 && a2 == 0; n++) begin
      @(negedge clk);
      if (bus.rd_strobe) a2 = 1;
    end
    chk("pre_rst_sampling", a2, 1);
    rst_n = 1'b0;
    #1;
    chk("sample_rst_strobe", bus.rd_strobe, 0);
    chk("sample_rst_rd_valid", bus.rd_valid, 0);
    chk("sample_rst_rd_data", bus.rd_data, 0);
    chk("sample_rst_busy", bus.busy, 0);
    chk("sample_rst_oe", dut.dq_oe_q, 0);
    rd_exp.delete();
    bus.rd_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    st = cyc;
    wr_word(8'h99, a1);
    chk("post_rst_no_turn", a1, st);
    wait_idle("post_rst");

    // Contention flag
`ifdef NAND_DQ_CONTENTION_EN
    force_val = 8'hFF;
    force_en  = 1'b1;
    wr_word(8'h00, a1);
    @(posedge clk); #1;
    chk("contention_set", bus.contention, 1);
    force_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("contention_hold", bus.contention, 1);
    bus.contention_clr = 1'b1;
    @(posedge clk); #1;
    bus.contention_clr = 1'b0;
    chk("contention_clear", bus.contention, 0);
`else
    wr_word(8'h00, a1);
    @(posedge clk); #1;
    chk("contention_off", bus.contention, 0);
    bus.contention_clr = 1'b1;
    @(posedge clk); #1;
    bus.contention_clr = 1'b0;
    chk("contention_off_clr", bus.contention, 0);
`endif
    wait_idle("final");

    repeat (3) @(posedge clk);
    #1;
    chk("wr_exp_drained", wr_exp.size(), 0);
    chk("rd_exp_drained", rd_exp.size(), 0);
    chk("no_drive_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
